vga_scandoubler_lb: RTL and testbench



---
 rtl/vga_scandoubler_lb.sv | 164 ++++++++++++++++
 tb/tb_vga_scandoubler_lb.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/vga_scandoubler_lb.sv
// Line-buffer scandoubler: each 15 kHz input line is written into one half of a
// ping-pong buffer while the other half is replayed twice at the full clk rate.
module vga_scandoubler_lb #(
  parameter int CW         = 3,
  parameter int AW         = 10,
  parameter int HSYNC_CLKS = 106,
  parameter int MIN_LINE   = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clk14en,
  input  logic          enable_scandoubling,
  input  logic [1:0]    scanline_level,
  input  logic [CW-1:0] ri,
  input  logic [CW-1:0] gi,
  input  logic [CW-1:0] bi,
  input  logic          hsync_ext_n,
  input  logic          vsync_ext_n,
  input  logic          csync_ext_n,
  output logic [CW-1:0] ro,
  output logic [CW-1:0] go,
  output logic [CW-1:0] bo,
  output logic          hsync,
  output logic          vsync
);
  localparam int PW = 3 * CW;
  localparam logic [AW:0] MIN_W = (AW+1)'(MIN_LINE);
  localparam logic [AW:0] HS_W  = (AW+1)'(HSYNC_CLKS);
  localparam logic [AW:0] FULL  = {1'b1, {AW{1'b0}}};
  localparam logic [AW:0] ONE_C = (AW+1)'(1);
  localparam logic [AW-1:0] ONE_A = AW'(1);

  logic [PW-1:0] mem [0:2**(AW+1)-1];
  logic [PW-1:0] pix_q;

  logic          hs_prev_q, hs_prev_d;
  logic          wb_q, wb_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic [AW:0]   len_q, len_d;
  logic [AW-1:0] rd_addr_q, rd_addr_d;
  logic          odd_q, odd_d;
  logic          vs_q, vs_d;
  logic [AW-1:0] pos1_q;
  logic          odd1_q, vs1_q;
  logic [CW-1:0] ro_q, go_q, bo_q, ro_d, go_d, bo_d;
  logic          hsync_q, vsync_q, hsync_d, vsync_d;
  logic          we;
  logic [AW:0]   waddr, raddr;
  logic [1:0]    lv;
  logic          line_start, accept;

  assign line_start = clk14en && hs_prev_q && !hsync_ext_n;
  assign accept     = line_start && (cnt_q >= MIN_W);

  function automatic logic [CW-1:0] atten(input logic [CW-1:0] x, input logic [1:0] l);
    case (l)
      2'd1:    atten = x - (x >> 2);
      2'd2:    atten = x >> 1;
      2'd3:    atten = x >> 2;
      default: atten = x;
    endcase
  endfunction

  // The strobe carrying the line start is pixel 0 of the new line, so the count
  // restarts at 1 and that pixel lands in the freshly selected bank.
  always_comb begin
    hs_prev_d = hs_prev_q;
    wb_d      = wb_q;
    cnt_d     = cnt_q;
    len_d     = len_q;
    vs_d      = vs_q;
    we        = 1'b0;
    waddr     = {wb_q, cnt_q[AW-1:0]};
    if (clk14en) begin
      hs_prev_d = hsync_ext_n;
      if (accept) begin
        wb_d  = ~wb_q;
        len_d = cnt_q;
        vs_d  = vsync_ext_n;
        cnt_d = ONE_C;
        we    = 1'b1;
        waddr = {~wb_q, {AW{1'b0}}};
      end else if (!cnt_q[AW]) begin
        cnt_d = cnt_q + ONE_C;
        we    = 1'b1;
      end
    end
    if (accept) begin
      rd_addr_d = '0;
      odd_d     = 1'b0;
    end else if ({1'b0, rd_addr_q} == len_q - ONE_C) begin
      rd_addr_d = '0;
      odd_d     = 1'b1;
    end else begin
      rd_addr_d = rd_addr_q + ONE_A;
      odd_d     = odd_q;
    end
    // Reading from the next-state bank keeps the read off the bank being written.
    raddr = {~wb_d, rd_addr_q};
  end

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= {ri, gi, bi};
    pix_q <= mem[raddr];
  end

  always_comb begin
    ro_d    = ri;
    go_d    = gi;
    bo_d    = bi;
    hsync_d = csync_ext_n;
    vsync_d = 1'b1;
    lv      = odd1_q ? scanline_level : 2'd0;
    if (enable_scandoubling) begin
      ro_d    = atten(pix_q[PW-1 -: CW], lv);
      go_d    = atten(pix_q[2*CW-1 -: CW], lv);
      bo_d    = atten(pix_q[CW-1:0], lv);
      hsync_d = ({1'b0, pos1_q} >= HS_W);
      vsync_d = vs1_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hs_prev_q <= 1'b1;
      wb_q      <= 1'b0;
      cnt_q     <= '0;
      len_q     <= FULL;
      rd_addr_q <= '0;
      odd_q     <= 1'b0;
      vs_q      <= 1'b1;
      pos1_q    <= '0;
      odd1_q    <= 1'b0;
      vs1_q     <= 1'b1;
      ro_q      <= '0;
      go_q      <= '0;
      bo_q      <= '0;
      hsync_q   <= 1'b1;
      vsync_q   <= 1'b1;
    end else begin
      hs_prev_q <= hs_prev_d;
      wb_q      <= wb_d;
      cnt_q     <= cnt_d;
      len_q     <= len_d;
      rd_addr_q <= rd_addr_d;
      odd_q     <= odd_d;
      vs_q      <= vs_d;
      pos1_q    <= rd_addr_q;
      odd1_q    <= odd_q;
      vs1_q     <= vs_q;
      ro_q      <= ro_d;
      go_q      <= go_d;
      bo_q      <= bo_d;
      hsync_q   <= hsync_d;
      vsync_q   <= vsync_d;
    end
  end

  assign ro    = ro_q;
  assign go    = go_q;
  assign bo    = bo_q;
  assign hsync = hsync_q;
  assign vsync = vsync_q;
endmodule

// File: tb/tb_vga_scandoubler_lb.sv
// Scoreboard bench: the driver pushes expected outputs tagged with the clock edge
// they must appear on; the monitor pops and compares on the falling edge.
module tb_vga_scandoubler_lb;
  localparam int CW = 3;
  localparam int AW = 10;
  localparam int HS = 106;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          clk14en = 1'b0;
  logic          en = 1'b1;
  logic [1:0]    lvl = 2'd0;
  logic [CW-1:0] ri = '0, gi = '0, bi = '0;
  logic          hs_n = 1'b1, vs_n = 1'b1, cs_n = 1'b1;
  logic [CW-1:0] ro, go, bo;
  logic          hsync, vsync;

  vga_scandoubler_lb #(.CW(CW), .AW(AW), .HSYNC_CLKS(HS), .MIN_LINE(16)) dut (
    .clk(clk), .rst_n(rst_n), .clk14en(clk14en), .enable_scandoubling(en),
    .scanline_level(lvl), .ri(ri), .gi(gi), .bi(bi),
    .hsync_ext_n(hs_n), .vsync_ext_n(vs_n), .csync_ext_n(cs_n),
    .ro(ro), .go(go), .bo(bo), .hsync(hsync), .vsync(vsync)
  );

  always #5 clk = ~clk;

  typedef struct {
    int              edge_n;
    logic [3*CW-1:0] rgb;
    logic            hs;
    logic            vs;
    bit              chk_rgb;
    string           name;
  } exp_t;

  exp_t sb[$];
  int cyc = 0;
  int checks = 0;
  int failures = 0;

  logic [3*CW-1:0] bp_rgb [8] = '{9'o777, 9'o123, 9'o456, 9'o700, 9'o070, 9'o007, 9'o000, 9'o654};
  logic [7:0]      bp_cs = 8'b0110_1001;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (sb.size() > 0 && sb[0].edge_n <= cyc) begin
        e = sb.pop_front();
        checks++;
        if (e.edge_n != cyc || hsync !== e.hs || vsync !== e.vs ||
            (e.chk_rgb && {ro, go, bo} !== e.rgb)) begin
          failures++;
          $display("FAIL %s edge=%0d now=%0d got rgb=%o hs=%b vs=%b want rgb=%o hs=%b vs=%b",
                   e.name, e.edge_n, cyc, {ro, go, bo}, hsync, vsync, e.rgb, e.hs, e.vs);
        end else begin
          $display("check %s edge=%0d rgb=%o hs=%b vs=%b", e.name, cyc, {ro, go, bo}, hsync, vsync);
        end
      end
    end
  end

  function automatic void push(input int en_n, input logic [3*CW-1:0] rgb, input logic hs,
                               input logic vs, input bit cr, input string nm);
    exp_t x;
    x.edge_n = en_n; x.rgb = rgb; x.hs = hs; x.vs = vs; x.chk_rgb = cr; x.name = nm;
    sb.push_back(x);
  endfunction

  // Previous line replayed from edge es+2: even copy then odd copy, len clk each.
  task automatic expect_lines(input int es, input int len, input int kind,
                              input logic [CW-1:0] oddv, input logic vs, input string nm);
    int pos [5];
    int p;
    logic [CW-1:0] v;
    pos = '{0, 5, 105, 106, 500};
    for (int i = 0; i < 6; i++) begin
      p = (i < 5) ? pos[i] : len - 1;
      v = (kind == 0) ? CW'(p % 8) : 3'd7;
      push(es + 2 + p, {v, v, v}, p >= HS, vs, 1'b1, {nm, "_even"});
    end
    for (int i = 0; i < 5; i++) begin
      p = pos[i];
      v = (kind == 0) ? CW'(p % 8) : oddv;
      push(es + 2 + len + p, {v, v, v}, p >= HS, vs, 1'b1, {nm, "_odd"});
    end
  endtask

  task automatic pix(input logic [CW-1:0] v, input logic h, input logic vsn, output int e);
    ri = v; gi = v; bi = v; hs_n = h; vs_n = vsn; clk14en = 1'b1;
    @(posedge clk); #1;
    e = cyc;
    clk14en = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic send_line(input int n, input int kind, input bit glitch, input logic vsn,
                           input bit chk, input int plen, input int pkind,
                           input logic [CW-1:0] poddv, input logic pvs, input string nm);
    int e;
    logic h;
    logic [CW-1:0] v;
    for (int i = 0; i < n; i++) begin
      h = glitch ? !(i < 3 || (i >= 5 && i < 32)) : !(i < 32);
      v = (kind == 0) ? CW'(i % 8) : 3'd7;
      pix(v, h, vsn, e);
      if (i == 0 && chk) expect_lines(e, plen, pkind, poddv, pvs, nm);
    end
  endtask

  initial begin
    int e;
    for (int k = 1; k <= 4; k++) push(k, 9'o000, 1'b1, 1'b1, 1'b1, "reset");
    push(111, 9'o000, 1'b0, 1'b1, 1'b0, "idle_hs");
    push(112, 9'o000, 1'b1, 1'b1, 1'b0, "idle_hs");
    push(1029, 9'o000, 1'b1, 1'b1, 1'b0, "idle_hs");
    push(1030, 9'o000, 1'b0, 1'b1, 1'b0, "idle_hs");
    push(1135, 9'o000, 1'b0, 1'b1, 1'b0, "idle_hs");
    push(1136, 9'o000, 1'b1, 1'b1, 1'b0, "idle_hs");
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b1;
    while (cyc < 1140) begin
      @(posedge clk); #1;
    end

    for (int i = 0; i < 20; i++) pix(3'd0, 1'b1, 1'b1, e);
    send_line(896, 0, 1'b0, 1'b1, 1'b0, 0, 0, 3'd0, 1'b1, "none");
    send_line(896, 0, 1'b0, 1'b1, 1'b1, 896, 0, 3'd0, 1'b1, "ramp_a");
    send_line(896, 0, 1'b0, 1'b0, 1'b1, 896, 0, 3'd0, 1'b0, "ramp_vs");
    send_line(896, 0, 1'b0, 1'b1, 1'b1, 896, 0, 3'd0, 1'b1, "ramp_b");
    send_line(896, 1, 1'b0, 1'b1, 1'b1, 896, 0, 3'd0, 1'b1, "ramp_c");
    lvl = 2'd1;
    send_line(896, 1, 1'b0, 1'b1, 1'b1, 896, 1, 3'd6, 1'b1, "lvl1");
    lvl = 2'd2;
    send_line(896, 1, 1'b0, 1'b1, 1'b1, 896, 1, 3'd3, 1'b1, "lvl2");
    lvl = 2'd3;
    send_line(896, 1, 1'b0, 1'b1, 1'b1, 896, 1, 3'd1, 1'b1, "lvl3");
    lvl = 2'd0;
    send_line(896, 0, 1'b1, 1'b1, 1'b1, 896, 1, 3'd7, 1'b1, "lvl0_glitch");
    send_line(1100, 0, 1'b0, 1'b1, 1'b1, 896, 0, 3'd0, 1'b1, "post_glitch");
    send_line(896, 0, 1'b0, 1'b1, 1'b1, 1024, 0, 3'd0, 1'b1, "overflow");

    en = 1'b0; lvl = 2'd3; vs_n = 1'b0;
    for (int i = 0; i < 8; i++) begin
      {ri, gi, bi} = bp_rgb[i];
      cs_n = bp_cs[i];
      push(cyc + 1, bp_rgb[i], bp_cs[i], 1'b1, 1'b1, "bypass");
      @(posedge clk); #1;
    end

    for (int t = 0; t < 100 && sb.size() > 0; t++) begin
      @(posedge clk); #1;
    end
    if (sb.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL drain pending=%0d want 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
